// File: rtl/bp_cfg_link_slave_if.sv
// Config-link request/response bus between the network endpoint (master)
// and the terminal decoder (slave).
interface bp_cfg_link_slave_if #(
   parameter int cfg_data_width_p = 32
);
   logic                        pkt_v;
   logic                        pkt_ready;
   logic                        pkt_w;
   logic [15:0]                 pkt_addr;
   logic [cfg_data_width_p-1:0] pkt_data;
   logic                        resp_v;
   logic [cfg_data_width_p-1:0] resp_data;
   logic                        resp_yumi;

   modport master (
      output pkt_v, pkt_w, pkt_addr, pkt_data, resp_yumi,
      input  pkt_ready, resp_v, resp_data
   );

   modport slave (
      input  pkt_v, pkt_w, pkt_addr, pkt_data, resp_yumi,
      output pkt_ready, resp_v, resp_data
   );
endinterface

// File: rtl/bp_cfg_link_slave.sv
// Config-link terminal decoder: chip/FE/BE/ME config registers plus CCE ucode RAM port.
// Read responses are built only when BP_CFG_LINK_READBACK_EN is defined.
module bp_cfg_link_slave #(
   parameter int                       vaddr_width_p          = 39,
   parameter int                       cfg_data_width_p       = 32,
   parameter int                       lce_id_width_p         = 4,
   parameter int                       cce_ucode_addr_width_p = 8,
   parameter logic [vaddr_width_p-1:0] reset_pc_p             = 'h8000_0000
) (
   input  logic                              clk_i,
   input  logic                              reset_i,
   bp_cfg_link_slave_if.slave                link,
   output logic                              clk_osc_o,
   output logic                              reset_o,
   output logic                              freeze_o,
   output logic                              icache_mode_o,
   output logic                              dcache_mode_o,
   output logic                              cce_mode_o,
   output logic [vaddr_width_p-1:0]          start_pc_o,
   output logic [lce_id_width_p-1:0]         num_lce_o,
   output logic                              cce_ucode_v_o,
   output logic                              cce_ucode_w_o,
   output logic [cce_ucode_addr_width_p-1:0] cce_ucode_addr_o,
   output logic [cfg_data_width_p-1:0]       cce_ucode_data_o,
   input  logic [cfg_data_width_p-1:0]       cce_ucode_data_i
);

   localparam logic [1:0] st_idle     = 2'd0;
   localparam logic [1:0] st_uc_issue = 2'd1;
`ifdef BP_CFG_LINK_READBACK_EN
   localparam logic [1:0] st_uc_wait  = 2'd2;
   localparam logic [1:0] st_resp     = 2'd3;
`endif

   logic [1:0] state_r, state_n;

   logic                              clk_osc_r;
   logic                              reset_r;
   logic                              freeze_r;
   logic                              icache_mode_r;
   logic                              dcache_mode_r;
   logic                              cce_mode_r;
   logic [vaddr_width_p-1:0]          start_pc_r;
   logic [lce_id_width_p-1:0]         num_lce_r;

   logic                              uc_w_r;
   logic [cce_ucode_addr_width_p-1:0] uc_addr_r;
   logic [cfg_data_width_p-1:0]       uc_data_r;

   logic accept;
   logic pkt_is_ucode;

   assign accept       = (state_r == st_idle) & link.pkt_v;
   assign pkt_is_ucode = (link.pkt_addr[15:12] == 4'h8);

   always_comb begin
      state_n = state_r;
      case (state_r)
         st_idle: begin
            if (link.pkt_v) begin
               if (pkt_is_ucode) begin
                  // Ucode traffic only reaches the RAM while the tile is frozen
                  if (freeze_r & link.pkt_w) begin
                     state_n = st_uc_issue;
                  end
`ifdef BP_CFG_LINK_READBACK_EN
                  else if (freeze_r) begin
                     state_n = st_uc_issue;
                  end else if (~link.pkt_w) begin
                     state_n = st_resp;
                  end
`endif
               end
`ifdef BP_CFG_LINK_READBACK_EN
               else if (~link.pkt_w) begin
                  state_n = st_resp;
               end
`endif
            end
         end
         st_uc_issue: begin
`ifdef BP_CFG_LINK_READBACK_EN
            state_n = uc_w_r ? st_idle : st_uc_wait;
`else
            state_n = st_idle;
`endif
         end
`ifdef BP_CFG_LINK_READBACK_EN
         st_uc_wait: state_n = st_resp;
         st_resp: begin
            if (link.resp_yumi) begin
               state_n = st_idle;
            end
         end
`endif
         default: state_n = st_idle;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_r       <= st_idle;
         clk_osc_r     <= 1'b0;
         reset_r       <= 1'b1;
         freeze_r      <= 1'b1;
         icache_mode_r <= 1'b0;
         dcache_mode_r <= 1'b0;
         cce_mode_r    <= 1'b0;
         start_pc_r    <= reset_pc_p;
         num_lce_r     <= '0;
         uc_w_r        <= 1'b0;
         uc_addr_r     <= '0;
         uc_data_r     <= '0;
      end else begin
         state_r <= state_n;
         if (accept & pkt_is_ucode) begin
            uc_w_r    <= link.pkt_w;
            uc_addr_r <= link.pkt_addr[cce_ucode_addr_width_p-1:0];
            uc_data_r <= link.pkt_data;
         end
         if (accept & link.pkt_w & ~pkt_is_ucode) begin
            case (link.pkt_addr)
               16'h0000: clk_osc_r     <= link.pkt_data[0];
               16'h0001: reset_r       <= link.pkt_data[0];
               16'h0002: freeze_r      <= link.pkt_data[0];
               16'h0022: icache_mode_r <= link.pkt_data[0];
               16'h0040: start_pc_r[31:0] <= link.pkt_data[31:0];
               16'h0041: start_pc_r[vaddr_width_p-1:32] <= link.pkt_data[vaddr_width_p-33:0];
               16'h0042: dcache_mode_r <= link.pkt_data[0];
               16'h0060: cce_mode_r    <= link.pkt_data[0];
               16'h0061: num_lce_r     <= link.pkt_data[lce_id_width_p-1:0];
               default: ;
            endcase
         end
      end
   end

`ifdef BP_CFG_LINK_READBACK_EN
   logic [cfg_data_width_p-1:0] rd_data;
   logic [cfg_data_width_p-1:0] resp_data_r;

   always_comb begin
      rd_data = '0;
      case (link.pkt_addr)
         16'h0000: rd_data[0] = clk_osc_r;
         16'h0001: rd_data[0] = reset_r;
         16'h0002: rd_data[0] = freeze_r;
         16'h0022: rd_data[0] = icache_mode_r;
         16'h0040: rd_data[31:0] = start_pc_r[31:0];
         16'h0041: rd_data[vaddr_width_p-33:0] = start_pc_r[vaddr_width_p-1:32];
         16'h0042: rd_data[0] = dcache_mode_r;
         16'h0060: rd_data[0] = cce_mode_r;
         16'h0061: rd_data[lce_id_width_p-1:0] = num_lce_r;
         default: ;
      endcase
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         resp_data_r <= '0;
      end else if (accept & ~link.pkt_w) begin
         // Dropped (unfrozen) ucode reads answer 0; frozen ones are overwritten in UC_WAIT
         resp_data_r <= pkt_is_ucode ? '0 : rd_data;
      end else if (state_r == st_uc_wait) begin
         resp_data_r <= cce_ucode_data_i;
      end
   end

   assign link.resp_v    = (state_r == st_resp);
   assign link.resp_data = resp_data_r;
`else
   logic unused_readback;
   assign unused_readback = ^{link.resp_yumi, cce_ucode_data_i};

   assign link.resp_v    = 1'b0;
   assign link.resp_data = '0;
`endif

   assign link.pkt_ready = (state_r == st_idle);

   assign clk_osc_o        = clk_osc_r;
   assign reset_o          = reset_r;
   assign freeze_o         = freeze_r;
   assign icache_mode_o    = icache_mode_r;
   assign dcache_mode_o    = dcache_mode_r;
   assign cce_mode_o       = cce_mode_r;
   assign start_pc_o       = start_pc_r;
   assign num_lce_o        = num_lce_r;

   assign cce_ucode_v_o    = (state_r == st_uc_issue);
   assign cce_ucode_w_o    = uc_w_r;
   assign cce_ucode_addr_o = uc_addr_r;
   assign cce_ucode_data_o = uc_data_r;

endmodule
